mux_nto1_rr: RTL
================

Name: mux_nto1_rr

Overview:
Parametrised N-input, W-bit registered multiplexer with valid/ready handshakes on every input and on the output. It generalises the single-bit 4-to-1 combinational mux to any width and channel count. Two modes are supported: direct select, steered by `sel`, and round-robin arbitration across the valid inputs. It sits between multiple producers and one consumer in datapaths that need a fair or steered merge with back-pressure.

Parameters:
- N, 4, number of input channels (N >= 2).
- W, 8, data width per channel in bits (W >= 1).
- SELW, $clog2(N), derived localparam; width of `sel` and `y_ch`. Not overridable.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = direct select by `sel`; 1 = round-robin arbitration.
- sel  in  SELW  channel index used in mode 0.
- d  in  N*W  flattened input data; channel i is `d[i*W +: W]`.
- d_valid  in  N  per-channel valid.
- d_ready  out  N  per-channel ready; combinational.
- y  out  W  registered output data.
- y_valid  out  1  output holds a valid word.
- y_ready  in  1  consumer accepts `y` this cycle.
- y_ch  out  SELW  index of the channel that supplied `y`.

Behaviour:
- Reset: when `rst`=1 at a clock edge:
  - `y`=0, `y_valid`=0, `y_ch`=0, round-robin pointer `ptr`=0.
  - While `rst`=1, `d_ready`=0 on all channels.
- Reset mid-operation: any word held in `y` is discarded with no handshake. Any input transfer offered in that cycle is not accepted.
- Output register: single entry.
  - `load_en` = !y_valid || y_ready.
  - When `y_valid` && `y_ready`, the output word is consumed.
  - If no new grant occurs in the same cycle, `y_valid` goes to 0 on the next edge.
- Channel choice (`chosen`, combinational):
  - Mode 0: `chosen` = `sel`. If `sel` >= N, no channel is chosen.
  - Mode 1: `chosen` = the first index i, searching `ptr`, `ptr`+1, … wrapping modulo N, for which `d_valid[i]`=1. If no `d_valid` bit is set, no channel is chosen.
- Ready: `d_ready[i]` = load_en && (i == chosen) && !rst. At most one `d_ready` bit is high in any cycle. In mode 0, `d_ready[sel]` may be high even when `d_valid[sel]`=0.
- Grant: an input transfer occurs when `d_valid[chosen]` && `d_ready[chosen]`. On the next edge:
  - `y` <= channel `chosen` data.
  - `y_ch` <= `chosen`.
  - `y_valid` <= 1.
- Latency: one cycle from input handshake to `y_valid`. Full throughput of one word per cycle is sustained when `y_ready` is held at 1.
- Back-pressure: while `y_valid`=1 and `y_ready`=0, all `d_ready` bits are 0, and `y`, `y_ch` and `y_valid` hold their values.
- Pointer update:
  - Only on a grant in mode 1: `ptr` <= (`chosen`+1) mod N. Wrap-around: `chosen`=N-1 gives `ptr`=0.
  - `ptr` holds on mode-0 grants and on idle cycles.
- Mode change: sampled combinationally each cycle. It affects only the next grant and never disturbs a word already held in `y`.
- Input data, `sel` and `mode` are don't-care when no grant occurs.

Optional Feature:
- Macro: MUX_XFER_CNT_EN.
- Defined:
  - Adds output port `xfer_cnt`, 16 bits, placed after `y_ch`.
  - Increments by 1 on each output handshake (`y_valid` && `y_ready`).
  - Saturates at 16'hFFFF.
  - Reset value 0; cleared by `rst`.
- Not defined: the port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset: `rst`=1 for 2 cycles with all `d_valid`=1 -> `y_valid`=0, `y`=0, `y_ch`=0, `d_ready`=4'b0000 during reset. With `mode`=1 after release, the first grant is channel 0.
- Direct select: N=4, W=8, `mode`=0, `sel`=2, d = {8'h44, 8'h33, 8'h22, 8'h11}, `d_valid`=4'b1111, `y_ready`=1 -> `d_ready`=4'b0100. Next cycle `y`=8'h33, `y_ch`=2, `y_valid`=1. With `sel`=1 instead, `y`=8'h22. The four cases (sel 0–3) give 8'h11, 8'h22, 8'h33, 8'h44.
- Round-robin fairness and wrap: `mode`=1, `d_valid`=4'b1011 held, `y_ready`=1 -> `y_ch` sequence is 0, 1, 3, 0, 1, 3. `ptr` wraps from 3 to 0.
- Back-pressure: `y_valid`=1, `y`=8'h22, `y_ready`=0 for 3 cycles with `d_valid`=4'b1111 -> `d_ready`=0, `y`=8'h22 held. When `y_ready`=1, a new grant loads in the same cycle and `y_valid` stays 1.
- Out-of-range and idle: `mode`=0, `sel`=3 with N=3, `d_valid`=3'b111 -> no grant, `y_valid` falls to 0 after the pending word is consumed. `mode`=1 with `d_valid`=0 -> `ptr` unchanged.
- Counter (MUX_XFER_CNT_EN): 5 output handshakes -> `xfer_cnt`=5. Preloaded to 16'hFFFE, then 3 handshakes -> 16'hFFFF. `rst` -> 0.

Source files
------------

// File: rtl/mux_nto1_rr.sv
// -----------------------------------------------------------------------------
// mux_nto1_rr
//
// Parametrised N-input, W-bit registered multiplexer with valid/ready
// handshakes on every input channel and on the single output. Two modes:
//   mode = 0 : direct select, the channel is chosen by `sel`
//   mode = 1 : round-robin arbitration across the valid inputs
//
// Parameters:
//   N    - number of input channels (N >= 2)
//   W    - data width per channel in bits (W >= 1)
//   SELW - derived width of `sel` / `y_ch` ($clog2(N)), not overridable
//
// Ports:
//   clk      in   clock, all state updates on the rising edge
//   rst      in   synchronous, active-high reset
//   mode     in   0 = direct select, 1 = round-robin
//   sel      in   channel index used in mode 0 (>= N selects nothing)
//   d        in   flattened input data, channel i is d[i*W +: W]
//   d_valid  in   per-channel valid
//   d_ready  out  per-channel ready (combinational, at most one bit high)
//   y        out  registered output data
//   y_valid  out  output register holds a valid word
//   y_ready  in   consumer accepts y this cycle
//   y_ch     out  index of the channel that supplied y
//   xfer_cnt out  saturating count of output handshakes
//                 (present only when MUX_XFER_CNT_EN is defined)
//
// Optional feature macro: MUX_XFER_CNT_EN
// -----------------------------------------------------------------------------
module mux_nto1_rr #(
    parameter  int unsigned N    = 4,
    parameter  int unsigned W    = 8,
    localparam int unsigned SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    input  logic [N*W-1:0]    d,
    input  logic [N-1:0]      d_valid,
    output logic [N-1:0]      d_ready,
    output logic [W-1:0]      y,
    output logic              y_valid,
    input  logic              y_ready,
    output logic [SELW-1:0]   y_ch
`ifdef MUX_XFER_CNT_EN
    ,
    output logic [15:0]       xfer_cnt
`endif
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [W-1:0]    y_q,       y_d;
    logic            y_valid_q, y_valid_d;
    logic [SELW-1:0] y_ch_q,    y_ch_d;
    logic [SELW-1:0] ptr_q,     ptr_d;

    // -------------------------------------------------------------------------
    // Channel choice
    // -------------------------------------------------------------------------
    logic            load_en;
    logic [SELW-1:0] chosen;
    logic            chosen_ok;
    logic [SELW-1:0] rr_hi;
    logic            rr_hi_ok;
    logic [SELW-1:0] rr_lo;
    logic            rr_lo_ok;
    logic [W-1:0]    chosen_data;
    logic            chosen_valid;
    logic            grant;

    // The output slot can take a new word when it is empty or being drained.
    assign load_en = !y_valid_q || y_ready;

    // Round-robin search split in two halves instead of a modular index:
    // rr_hi is the lowest valid index at or above ptr, rr_lo the lowest valid
    // index overall. Preferring rr_hi and falling back to rr_lo gives the
    // first valid channel searching ptr, ptr+1, ... wrapping modulo N.
    always_comb begin
        rr_hi    = '0;
        rr_hi_ok = 1'b0;
        rr_lo    = '0;
        rr_lo_ok = 1'b0;
        for (int unsigned i = N; i > 0; i--) begin
            if (d_valid[i-1]) begin
                rr_lo    = SELW'(i-1);
                rr_lo_ok = 1'b1;
                if (SELW'(i-1) >= ptr_q) begin
                    rr_hi    = SELW'(i-1);
                    rr_hi_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        chosen    = '0;
        chosen_ok = 1'b0;
        if (mode == 1'b0) begin
            // Indices >= N are possible when N is not a power of two.
            if (32'(sel) < N) begin
                chosen    = sel;
                chosen_ok = 1'b1;
            end
        end else begin
            if (rr_hi_ok) begin
                chosen    = rr_hi;
                chosen_ok = 1'b1;
            end else if (rr_lo_ok) begin
                chosen    = rr_lo;
                chosen_ok = 1'b1;
            end
        end
    end

    // Data/valid of the chosen channel and the per-channel ready decode.
    always_comb begin
        chosen_data  = '0;
        chosen_valid = 1'b0;
        d_ready      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (chosen_ok && (SELW'(i) == chosen)) begin
                chosen_data  = d[i*W +: W];
                chosen_valid = d_valid[i];
                d_ready[i]   = load_en && !rst;
            end
        end
    end

    assign grant = chosen_ok && chosen_valid && load_en && !rst;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        y_d       = y_q;
        y_valid_d = y_valid_q;
        y_ch_d    = y_ch_q;
        ptr_d     = ptr_q;

        if (grant) begin
            y_d       = chosen_data;
            y_ch_d    = chosen;
            y_valid_d = 1'b1;
            if (mode) begin
                if (chosen == SELW'(N-1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = chosen + SELW'(1);
                end
            end
        end else if (y_ready) begin
            // Word consumed with nothing to replace it; data/ch are kept.
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_ch_q    <= '0;
            ptr_q     <= '0;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            y_ch_q    <= y_ch_d;
            ptr_q     <= ptr_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign y_ch    = y_ch_q;

    // -------------------------------------------------------------------------
    // Optional handshake counter
    // -------------------------------------------------------------------------
`ifdef MUX_XFER_CNT_EN
    logic [15:0] xfer_cnt_q, xfer_cnt_d;

    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (y_valid_q && y_ready && (xfer_cnt_q != '1)) begin
            xfer_cnt_d = xfer_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule
